// File: rtl/ahb_slave_sram.sv
// AHB-Lite slave SRAM: word-organised memory with byte-lane writes and a two-cycle ERROR response.
// Latency: the data phase follows the accepted address phase and stretches by WAIT_STATES cycles (ERROR always takes 2).
// Backpressure: hreadyout is low in WAIT and ERR1; a new address phase is taken only while hreadyout and hready_in are both high.
//
// Ports:
//   hclk, hreset       bus clock (rising edge), asynchronous active-high reset
//   hsel, hready_in    slave select and global bus ready from the arbiter
//   haddr, htrans, hwrite, hsize, hburst   address-phase controls (hburst unused)
//   hwdata             write data, valid in the data phase
//   hreadyout, hresp, hrdata   per-slave response back to the arbiter
module ahb_slave_sram #(
    parameter logic [31:0] BASE_ADDR   = 32'd0,
    parameter int          DEPTH       = 8,
    parameter int          WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic        hready_in,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);
    localparam logic [32:0] WIN_BYTES = 33'(4 * DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    state_t        go_state;

    logic [31:0]   mem [DEPTH];

    // Latched address-phase attributes for the pending data phase.
    logic [3:0]    cnt;
    logic [IW-1:0] idx;
    logic          wr;
    logic [3:0]    mask;

    // Address-phase decode.
    logic [32:0]   off;
    logic          in_win;
    logic          misaligned;
    logic          ap_err;
    logic [3:0]    ap_mask;
    logic [IW-1:0] ap_idx;
    logic          slave_rdy;
    logic          accept;

    // Addresses below BASE_ADDR wrap to a huge 33-bit offset, so one
    // compare covers both ends of the window.
    assign off    = {1'b0, haddr} - {1'b0, BASE_ADDR};
    assign in_win = (off < WIN_BYTES);
    assign ap_idx = off[IW+1:2];

    assign misaligned = ((hsize == 3'b001) && haddr[0]) ||
                        ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
    assign ap_err     = !in_win || (hsize > 3'b010) || misaligned;

    always_comb begin
        ap_mask = 4'b0000;
        case (hsize)
            3'b000:  ap_mask = 4'b0001 << haddr[1:0];
            3'b001:  ap_mask = haddr[1] ? 4'b1100 : 4'b0011;
            3'b010:  ap_mask = 4'b1111;
            default: ap_mask = 4'b0000;
        endcase
    end

    // Own readiness also gates acceptance so a mis-wired hready_in can never
    // start a new transfer over a stalled data phase.
    assign slave_rdy = !((state == S_WAIT) || (state == S_ERR1));
    assign accept    = hsel && hready_in && htrans[1] && slave_rdy;

    logic unused_inputs;
    assign unused_inputs = ^{hburst, htrans[0]};

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            idx   <= '0;
            wr    <= 1'b0;
            mask  <= 4'b0000;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt  <= WS;
                idx  <= ap_idx;
                wr   <= hwrite;
                mask <= ap_mask;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        go_state  = S_DATA;
        hreadyout = 1'b1;
        hresp     = 2'b00;
        hrdata    = 32'd0;

        if (ap_err) begin
            go_state = S_ERR1;
        end else if (WS != 4'd0) begin
            go_state = S_WAIT;
        end

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = go_state;
                end
            end
            S_WAIT: begin
                hreadyout = 1'b0;
                if (cnt == 4'd1) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                // Reading the array combinationally gives read-after-write
                // forwarding for free: a pipelined read sees the word the
                // preceding write merged in on the shared edge.
                if (!wr) begin
                    hrdata = mem[idx];
                end
                state_nxt = accept ? go_state : S_IDLE;
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 2'b01;
                state_nxt = S_ERR2;
            end
            S_ERR2: begin
                hresp     = 2'b01;
                state_nxt = accept ? go_state : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Writes land on the edge closing the DATA cycle; error paths never reach DATA.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if ((state == S_DATA) && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) begin
                    mem[idx][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_sram.sv
module tb_ahb_slave_sram;

    localparam logic [31:0] B0 = 32'h0000_1000;
    localparam logic [31:0] B1 = 32'h0000_2000;
    localparam logic [1:0]  OK  = 2'b00;
    localparam logic [1:0]  ERR = 2'b01;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel0, hsel1;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic        hreadyout0, hreadyout1;
    logic [1:0]  hresp0, hresp1;
    logic [31:0] hrdata0, hrdata1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          waits;
    } exp_t;

    exp_t sb[$];

    always #5 hclk = ~hclk;

    ahb_slave_sram #(.BASE_ADDR(B0), .DEPTH(8), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel0), .hready_in(hreadyout0),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata),
        .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
    );

    ahb_slave_sram #(.BASE_ADDR(B1), .DEPTH(8), .WAIT_STATES(2)) u_dut1 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel1), .hready_in(hreadyout1),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata),
        .hreadyout(hreadyout1), .hresp(hresp1), .hrdata(hrdata1)
    );

    function automatic logic rdy(input int d);
        return (d == 0) ? hreadyout0 : hreadyout1;
    endfunction

    function automatic logic [1:0] rsp(input int d);
        return (d == 0) ? hresp0 : hresp1;
    endfunction

    function automatic logic [31:0] rdat(input int d);
        return (d == 0) ? hrdata0 : hrdata1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] rd, input logic [1:0] resp, input int waits);
        exp_t e;
        e.tag   = tag;
        e.rdata = rd;
        e.resp  = resp;
        e.waits = waits;
        sb.push_back(e);
    endtask

    task automatic drive_ap(input int d, input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel0  = (d == 0);
        hsel1  = (d == 1);
        haddr  = a;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = sz;
        hburst = 3'b000;
    endtask

    // Entered just after the edge that accepted an address phase, with the
    // next cycle's address-phase signals already driven. Leaves just after
    // the edge that closes the data phase.
    task automatic finish_dphase(input int d);
        exp_t e;
        int   waits;
        bit   done;
        e     = sb.pop_front();
        waits = 0;
        done  = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge hclk);
            if (rdy(d)) begin
                done = 1'b1;
            end else begin
                check({e.tag, "_stall_resp"}, 32'(rsp(d)), 32'(e.resp));
                waits++;
                @(posedge hclk); #1;
            end
        end
        check({e.tag, "_ready"}, 32'(rdy(d)), 32'd1);
        check({e.tag, "_resp"}, 32'(rsp(d)), 32'(e.resp));
        check({e.tag, "_rdata"}, rdat(d), e.rdata);
        check({e.tag, "_waits"}, 32'(waits), 32'(e.waits));
        @(posedge hclk); #1;
    endtask

    task automatic xfer(input int d, input string tag, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic [1:0] exp_resp, input int exp_waits);
        push(tag, exp_rd, exp_resp, exp_waits);
        drive_ap(d, wr, a, sz);
        @(posedge hclk); #1;
        htrans = 2'b00;
        hwdata = wd;
        finish_dphase(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        hreset = 1'b1;
        hsel0  = 1'b0;
        hsel1  = 1'b0;
        haddr  = 32'd0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b010;
        hburst = 3'b000;
        hwdata = 32'd0;

        repeat (2) @(posedge hclk);
        @(negedge hclk);
        check("rst_rdy0", 32'(hreadyout0), 32'd1);
        check("rst_resp0", 32'(hresp0), 32'd0);
        check("rst_rdata0", hrdata0, 32'd0);
        check("rst_rdy1", 32'(hreadyout1), 32'd1);
        check("rst_resp1", 32'(hresp1), 32'd0);
        check("rst_rdata1", hrdata1, 32'd0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(posedge hclk); #1;

        // Basic write/read with no wait states.
        xfer(0, "wr_deadbeef", 1'b1, B0 + 32'd4, 3'b010, 32'hDEAD_BEEF, 32'd0, OK, 0);
        xfer(0, "rd_deadbeef", 1'b0, B0 + 32'd4, 3'b010, 32'd0, 32'hDEAD_BEEF, OK, 0);

        // Two wait states on the second slave.
        xfer(1, "ws_wr", 1'b1, B1 + 32'd8, 3'b010, 32'h1234_5678, 32'd0, OK, 2);
        xfer(1, "ws_rd", 1'b0, B1 + 32'd8, 3'b010, 32'd0, 32'h1234_5678, OK, 2);

        // Byte lane write: other hwdata lanes carry junk that must be ignored.
        xfer(0, "byte_base", 1'b1, B0, 3'b010, 32'h1122_3344, 32'd0, OK, 0);
        xfer(0, "byte_wr", 1'b1, B0 + 32'd2, 3'b000, 32'hFFAB_FFFF, 32'd0, OK, 0);
        xfer(0, "byte_rd", 1'b0, B0, 3'b010, 32'd0, 32'h11AB_3344, OK, 0);

        // Pipelined upper-half write then read of the same word.
        push("fwd_wr", 32'd0, OK, 0);
        push("fwd_rd", 32'hCAFE_BEEF, OK, 0);
        drive_ap(0, 1'b1, B0 + 32'd6, 3'b001);
        @(posedge hclk); #1;
        hwdata = 32'hCAFE_1234;
        drive_ap(0, 1'b0, B0 + 32'd4, 3'b010);
        finish_dphase(0);
        htrans = 2'b00;
        finish_dphase(0);

        // Pipelined write, read, read chain.
        push("chain_wr", 32'd0, OK, 0);
        push("chain_rd5", 32'h0BAD_F00D, OK, 0);
        push("chain_rd1", 32'hCAFE_BEEF, OK, 0);
        drive_ap(0, 1'b1, B0 + 32'd20, 3'b010);
        @(posedge hclk); #1;
        hwdata = 32'h0BAD_F00D;
        drive_ap(0, 1'b0, B0 + 32'd20, 3'b010);
        finish_dphase(0);
        drive_ap(0, 1'b0, B0 + 32'd4, 3'b010);
        finish_dphase(0);
        htrans = 2'b00;
        finish_dphase(0);

        // Error responses; none may disturb word 0.
        xfer(0, "err_oow_wr", 1'b1, B0 + 32'd32, 3'b010, 32'h5555_5555, 32'd0, ERR, 1);
        xfer(0, "err_mis_word", 1'b1, B0 + 32'd1, 3'b010, 32'h6666_6666, 32'd0, ERR, 1);
        xfer(0, "err_mis_half", 1'b1, B0 + 32'd3, 3'b001, 32'h7777_7777, 32'd0, ERR, 1);
        xfer(0, "err_size", 1'b1, B0, 3'b011, 32'h8888_8888, 32'd0, ERR, 1);
        xfer(0, "err_below_rd", 1'b0, B0 - 32'd4, 3'b010, 32'd0, 32'd0, ERR, 1);
        xfer(0, "err_oow_rd", 1'b0, B0 + 32'd32, 3'b010, 32'd0, 32'd0, ERR, 1);
        xfer(0, "after_err_rd", 1'b0, B0, 3'b010, 32'd0, 32'h11AB_3344, OK, 0);
        xfer(0, "last_word_rd", 1'b0, B0 + 32'd28, 3'b010, 32'd0, 32'd0, OK, 0);
        xfer(1, "err_ws_rd", 1'b0, B1 + 32'd32, 3'b010, 32'd0, 32'd0, ERR, 1);

        // Unselected NONSEQ, then BUSY, then IDLE: no transfer may start.
        hsel0  = 1'b0;
        hsel1  = 1'b0;
        haddr  = B0;
        htrans = 2'b10;
        hwrite = 1'b1;
        hsize  = 3'b010;
        hwdata = 32'h9999_9999;
        @(posedge hclk); #1;
        hsel0  = 1'b1;
        htrans = 2'b01;
        @(posedge hclk); #1;
        htrans = 2'b00;
        @(posedge hclk); #1;
        @(negedge hclk);
        check("nosel_rdy", 32'(hreadyout0), 32'd1);
        check("nosel_resp", 32'(hresp0), 32'd0);
        @(posedge hclk); #1;
        xfer(0, "nosel_rd", 1'b0, B0, 3'b010, 32'd0, 32'h11AB_3344, OK, 0);

        // Reset during the wait state of a write.
        drive_ap(1, 1'b1, B1 + 32'd12, 3'b010);
        @(posedge hclk); #1;
        htrans = 2'b00;
        hwdata = 32'hCAFE_F00D;
        @(negedge hclk);
        check("rst_mid_wait_stall", 32'(hreadyout1), 32'd0);
        hreset = 1'b1;
        #1;
        check("rst_mid_rdy", 32'(hreadyout1), 32'd1);
        check("rst_mid_resp", 32'(hresp1), 32'd0);
        check("rst_mid_rdata", hrdata1, 32'd0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(posedge hclk); #1;
        xfer(1, "rst_target_rd", 1'b0, B1 + 32'd12, 3'b010, 32'd0, 32'd0, OK, 2);
        xfer(1, "rst_clear_rd", 1'b0, B1 + 32'd8, 3'b010, 32'd0, 32'd0, OK, 2);
        xfer(0, "rst_clear_rd0", 1'b0, B0, 3'b010, 32'd0, 32'd0, OK, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
